// File: rtl/seg7_pkg.sv
// seg7_pkg: active-low 7-segment patterns (bit order g..a) and display FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SHOW = 1'b1
    } state_t;

    function automatic logic [6:0] seg_of(input logic [2:0] idx);
        case (idx)
            3'd0:    return SEG_0;
            3'd1:    return SEG_1;
            3'd2:    return SEG_2;
            3'd3:    return SEG_3;
            3'd4:    return SEG_4;
            3'd5:    return SEG_5;
            3'd6:    return SEG_6;
            default: return SEG_7;
        endcase
    endfunction

endpackage

// File: rtl/fifo2.sv
// fifo2: 2-entry x 4-bit FIFO; push while full and pop while empty are ignored.
module fifo2 (
    input  logic       clk,
    input  logic       clrn,
    input  logic       push,
    input  logic       pop,
    input  logic [3:0] din,
    output logic [3:0] dout,
    output logic       full,
    output logic       empty,
    output logic [1:0] count
);

    logic [3:0] mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic       do_push;
    logic       do_pop;

    assign full    = count == 2'd2;
    assign empty   = count == 2'd0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            wr_ptr <= wr_ptr ^ do_push;
            rd_ptr <= rd_ptr ^ do_pop;
            count  <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dec38_display.sv
// dec38_display: buffers encoder words, decodes to one-hot LEDs / 7-seg,
// and holds each word on the display for HOLD_CYCLES clocks.
module dec38_display
    import seg7_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_code,
    output logic [7:0] led,
    output logic [6:0] seg,
    output logic       busy
);

    localparam int TW = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0] T_LOAD = TW'(HOLD_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic          load;
    logic          push;
    logic          full;
    logic          empty;
    logic [1:0]    count;
    logic [3:0]    head;

    assign in_ready = count != 2'd2;
    assign push     = in_valid && !full;
    assign busy     = state == S_SHOW;

    fifo2 u_fifo (
        .clk   (clk),
        .clrn  (clrn),
        .push  (push),
        .pop   (load),
        .din   (in_code),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Reload straight from timer==0 so back-to-back words show with no gap.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        load      = 1'b0;
        if (state == S_IDLE) begin
            if (!empty) begin
                load      = 1'b1;
                state_nxt = S_SHOW;
                timer_nxt = T_LOAD;
            end
        end else if (timer != '0) begin
            timer_nxt = timer - TW'(1);
        end else if (!empty) begin
            load      = 1'b1;
            timer_nxt = T_LOAD;
        end else begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= S_IDLE;
            timer <= '0;
            led   <= 8'h00;
            seg   <= SEG_BLANK;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            if (load) begin
                led <= head[0] ? 8'b1 << head[3:1] : 8'h00;
                seg <= head[0] ? seg_of(head[3:1]) : SEG_BLANK;
            end
        end
    end

endmodule

// File: tb/tb_dec38_display.sv
// tb_dec38_display: directed vectors for dec38_display with HOLD_CYCLES=4.
module tb_dec38_display;
    import seg7_pkg::*;

    logic       clk = 1'b0;
    logic       clrn = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_code = 4'h0;
    logic [7:0] led;
    logic [6:0] seg;
    logic       busy;
    int         checks = 0;
    int         errors = 0;

    dec38_display #(.HOLD_CYCLES(4)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_code  (in_code),
        .led      (led),
        .seg      (seg),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input logic [7:0] l, input logic [6:0] s, input logic b);
        chk({tag, " led"}, 32'(led), 32'(l));
        chk({tag, " seg"}, 32'(seg), 32'(s));
        chk({tag, " busy"}, 32'(busy), 32'(b));
    endtask

    initial begin
        // Asynchronous reset before the first clock edge
        #3 clrn = 1'b0;
        #1;
        chk_disp("reset", 8'h00, SEG_BLANK, 1'b0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        clrn = 1'b1;
        step();
        chk_disp("post reset", 8'h00, SEG_BLANK, 1'b0);

        // Single word: index 5, flag 1
        in_valid = 1'b1;
        in_code  = 4'b1011;
        step();
        in_valid = 1'b0;
        chk_disp("single N", 8'h00, SEG_BLANK, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_disp("single dwell", 8'b0010_0000, SEG_5, 1'b1);
        end
        step();
        chk_disp("single idle", 8'b0010_0000, SEG_5, 1'b0);

        // Burst of three: digits 0, 7, 3
        in_valid = 1'b1;
        in_code  = 4'b0001;
        step();
        chk("burst in_ready N", 32'(in_ready), 32'd1);
        in_code = 4'b1111;
        step();
        chk_disp("burst N+1", 8'h01, SEG_0, 1'b1);
        in_code = 4'b0111;
        step();
        in_valid = 1'b0;
        chk("burst in_ready N+2", 32'(in_ready), 32'd0);
        for (int k = 3; k <= 13; k++) begin
            step();
            chk("burst in_ready", 32'(in_ready), (k < 5) ? 32'd0 : 32'd1);
            chk_disp("burst", (k < 5) ? 8'h01 : (k < 9) ? 8'h80 : 8'h08,
                     (k < 5) ? SEG_0 : (k < 9) ? SEG_7 : SEG_3, k < 13);
        end

        // Flag zero still occupies a full blank dwell
        in_valid = 1'b1;
        in_code  = 4'b0110;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_disp("flag0 dwell", 8'h00, SEG_BLANK, 1'b1);
        end
        step();
        chk_disp("flag0 idle", 8'h00, SEG_BLANK, 1'b0);

        // Full FIFO: digits 4, 5, 6 then digit 1 held while full
        in_valid = 1'b1;
        in_code  = 4'b1001;
        step();
        in_code = 4'b1011;
        step();
        in_code = 4'b1101;
        step();
        in_code = 4'b0011;
        chk("full in_ready N+2", 32'(in_ready), 32'd0);
        step();
        step();
        chk("full in_ready N+4", 32'(in_ready), 32'd0);
        chk_disp("full N+4", 8'h10, SEG_4, 1'b1);
        step();
        chk("full no accept on pop", 32'(in_ready), 32'd1);
        chk_disp("full N+5", 8'h20, SEG_5, 1'b1);
        step();
        in_valid = 1'b0;
        chk("full accepted N+6", 32'(in_ready), 32'd0);
        for (int k = 7; k <= 17; k++) begin
            step();
            chk_disp("full order", (k < 9) ? 8'h20 : (k < 13) ? 8'h40 : 8'h02,
                     (k < 9) ? SEG_5 : (k < 13) ? SEG_6 : SEG_1, k < 17);
        end

        // Reset mid-SHOW with two words buffered
        in_valid = 1'b1;
        in_code  = 4'b0001;
        step();
        in_code = 4'b0011;
        step();
        in_code = 4'b0101;
        step();
        in_valid = 1'b0;
        chk("midreset full", 32'(in_ready), 32'd0);
        #2 clrn = 1'b0;
        #1;
        chk_disp("midreset", 8'h00, SEG_BLANK, 1'b0);
        chk("midreset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        clrn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_disp("midreset discard", 8'h00, SEG_BLANK, 1'b0);
        end
        in_valid = 1'b1;
        in_code  = 4'b1101;
        step();
        in_valid = 1'b0;
        chk_disp("after reset N", 8'h00, SEG_BLANK, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_disp("after reset dwell", 8'h40, SEG_6, 1'b1);
        end
        step();
        chk_disp("after reset idle", 8'h40, SEG_6, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
